mem_port_arbiter: RTL and testbench

- Shares one downstream memory request/response port between the instruction-fetch requester (index 0) and the load/store requester (index 1) of the intirvx core.
- Sits between the core's two memory managers and a single memory or interconnect port.
- Round-robin arbitration with one registered request stage.
- An in-order tracking FIFO steers each downstream response back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch (0) and load/store (1).
// Round-robin grant into a single request register; an in-order owner FIFO routes responses back.
module mem_port_arbiter #(
    parameter int ALEN    = 32,
    parameter int XLEN    = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            m_req_valid_i,
    output logic [1:0]            m_req_ready_o,
    input  logic [2*ALEN-1:0]     m_req_adr_i,
    input  logic [1:0]            m_req_write_i,
    input  logic [2*XLEN-1:0]     m_req_wdata_i,
    input  logic [2*XLEN/8-1:0]   m_req_wstrb_i,
    output logic [1:0]            m_rsp_valid_o,
    output logic [XLEN-1:0]       m_rsp_rdata_o,
    output logic                  m_rsp_err_o,
    output logic                  s_req_valid_o,
    input  logic                  s_req_ready_i,
    output logic [ALEN-1:0]       s_req_adr_o,
    output logic                  s_req_write_o,
    output logic [XLEN-1:0]       s_req_wdata_o,
    output logic [XLEN/8-1:0]     s_req_wstrb_o,
    input  logic                  s_rsp_valid_i,
    input  logic [XLEN-1:0]       s_rsp_rdata_i,
    input  logic                  s_rsp_err_i
);

    localparam int SW    = XLEN / 8;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic               s_valid_q, s_valid_d;
    logic [ALEN-1:0]    adr_q, adr_d;
    logic               write_q, write_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]      wstrb_q, wstrb_d;
    logic               rr_q, rr_d;
    logic [MAX_OUT-1:0] order_q, order_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept_s;
    logic               win_s;
    logic               push_s;
    logic               pop_s;
    logic               head_s;

    // Arbitration and response steering; a pop never frees room for a same-cycle grant.
    always_comb begin
        accept_s = rst_n && (!s_valid_q || s_req_ready_i) && (cnt_q < CNT_MAX);
        if (m_req_valid_i == 2'b11) begin
            win_s = rr_q;
        end else if (m_req_valid_i[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        push_s = accept_s && (m_req_valid_i != 2'b00);
        if (push_s) begin
            m_req_ready_o = win_s ? 2'b10 : 2'b01;
        end else begin
            m_req_ready_o = 2'b00;
        end
        pop_s  = s_rsp_valid_i && (cnt_q != {CNT_W{1'b0}});
        head_s = order_q[rd_ptr_q];
        if (pop_s) begin
            m_rsp_valid_o = head_s ? 2'b10 : 2'b01;
        end else begin
            m_rsp_valid_o = 2'b00;
        end
    end

    assign m_rsp_rdata_o = s_rsp_rdata_i;
    assign m_rsp_err_o   = s_rsp_err_i;
    assign s_req_valid_o = s_valid_q;
    assign s_req_adr_o   = adr_q;
    assign s_req_write_o = write_q;
    assign s_req_wdata_o = wdata_q;
    assign s_req_wstrb_o = wstrb_q;

    // Next state of the request register, round-robin pointer and owner FIFO.
    always_comb begin
        s_valid_d = s_valid_q;
        adr_d     = adr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rr_d      = rr_q;
        order_d   = order_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_s) begin
            s_valid_d = 1'b1;
            adr_d     = win_s ? m_req_adr_i[2*ALEN-1:ALEN]   : m_req_adr_i[ALEN-1:0];
            write_d   = win_s ? m_req_write_i[1]             : m_req_write_i[0];
            wdata_d   = win_s ? m_req_wdata_i[2*XLEN-1:XLEN] : m_req_wdata_i[XLEN-1:0];
            wstrb_d   = win_s ? m_req_wstrb_i[2*SW-1:SW]     : m_req_wstrb_i[SW-1:0];
            rr_d      = ~win_s;
            order_d[wr_ptr_q] = win_s;
            wr_ptr_d  = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else if (s_valid_q && s_req_ready_i) begin
            s_valid_d = 1'b0;
        end else begin
            s_valid_d = s_valid_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset drops all in-flight tracking and prefers load/store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q <= 1'b0;
            adr_q     <= {ALEN{1'b0}};
            write_q   <= 1'b0;
            wdata_q   <= {XLEN{1'b0}};
            wstrb_q   <= {SW{1'b0}};
            rr_q      <= 1'b1;
            order_q   <= {MAX_OUT{1'b0}};
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            s_valid_q <= s_valid_d;
            adr_q     <= adr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rr_q      <= rr_d;
            order_q   <= order_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic for mem_port_arbiter, checked against a
// transaction-level model built from queues of owners and pending downstream responses.
module tb_mem_port_arbiter;

    localparam int ALEN    = 32;
    localparam int XLEN    = 32;
    localparam int SW      = XLEN / 8;
    localparam int MAX_OUT = 4;

    logic            clk;
    logic            rst_n;
    logic [1:0]      m_req_valid;
    logic [1:0]      m_req_ready;
    logic [31:0]     adr [2];
    logic            wr  [2];
    logic [31:0]     wd  [2];
    logic [3:0]      ws  [2];
    logic [63:0]     m_req_adr;
    logic [1:0]      m_req_write;
    logic [63:0]     m_req_wdata;
    logic [7:0]      m_req_wstrb;
    logic [1:0]      m_rsp_valid;
    logic [31:0]     m_rsp_rdata;
    logic            m_rsp_err;
    logic            s_req_valid;
    logic            s_req_ready;
    logic [31:0]     s_req_adr;
    logic            s_req_write;
    logic [31:0]     s_req_wdata;
    logic [3:0]      s_req_wstrb;
    logic            s_rsp_valid;
    logic [31:0]     s_rsp_rdata;
    logic            s_rsp_err;

    assign m_req_adr   = {adr[1], adr[0]};
    assign m_req_write = {wr[1], wr[0]};
    assign m_req_wdata = {wd[1], wd[0]};
    assign m_req_wstrb = {ws[1], ws[0]};

    mem_port_arbiter #(.ALEN(ALEN), .XLEN(XLEN), .MAX_OUT(MAX_OUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_req_valid_i (m_req_valid),
        .m_req_ready_o (m_req_ready),
        .m_req_adr_i   (m_req_adr),
        .m_req_write_i (m_req_write),
        .m_req_wdata_i (m_req_wdata),
        .m_req_wstrb_i (m_req_wstrb),
        .m_rsp_valid_o (m_rsp_valid),
        .m_rsp_rdata_o (m_rsp_rdata),
        .m_rsp_err_o   (m_rsp_err),
        .s_req_valid_o (s_req_valid),
        .s_req_ready_i (s_req_ready),
        .s_req_adr_o   (s_req_adr),
        .s_req_write_o (s_req_write),
        .s_req_wdata_o (s_req_wdata),
        .s_req_wstrb_o (s_req_wstrb),
        .s_rsp_valid_i (s_rsp_valid),
        .s_rsp_rdata_i (s_rsp_rdata),
        .s_rsp_err_i   (s_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          owner_q[$];
    int          mem_pend;
    bit          mv;
    bit          rr;
    logic [31:0] e_adr;
    logic        e_wr;
    logic [31:0] e_wd;
    logic [3:0]  e_ws;
    logic [1:0]  last_grant;
    bit          pend [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: called just after a negedge with inputs already driven.
    task automatic step();
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        bit         acc;
        int         win;
        #2;
        acc     = (!mv || s_req_ready) && (owner_q.size() < MAX_OUT);
        exp_rdy = 2'b00;
        win     = 0;
        if (acc && m_req_valid != 2'b00) begin
            win     = (m_req_valid == 2'b11) ? int'(rr) : (m_req_valid[1] ? 1 : 0);
            exp_rdy = 2'(1 << win);
        end
        exp_rsp = 2'b00;
        if (s_rsp_valid) begin
            if (owner_q.size() > 0) exp_rsp = 2'(1 << owner_q[0]);
            else $display("protocol error: stray downstream response at t=%0t", $time);
        end
        check("m_req_ready", m_req_ready, exp_rdy);
        check("s_req_valid", s_req_valid, mv);
        if (mv) begin
            check("s_req_adr", s_req_adr, e_adr);
            check("s_req_write", s_req_write, e_wr);
            check("s_req_wdata", s_req_wdata, e_wd);
            check("s_req_wstrb", s_req_wstrb, e_ws);
        end
        check("m_rsp_valid", m_rsp_valid, exp_rsp);
        if (exp_rsp != 2'b00) begin
            check("m_rsp_rdata", m_rsp_rdata, s_rsp_rdata);
            check("m_rsp_err", m_rsp_err, s_rsp_err);
        end
        last_grant = exp_rdy;
        @(posedge clk);
        if (exp_rsp != 2'b00) void'(owner_q.pop_front());
        if (s_rsp_valid && mem_pend > 0) mem_pend--;
        if (mv && s_req_ready) begin
            mem_pend++;
            mv = 1'b0;
        end
        if (exp_rdy != 2'b00) begin
            owner_q.push_back(win);
            rr    = (win == 0);
            mv    = 1'b1;
            e_adr = adr[win];
            e_wr  = wr[win];
            e_wd  = wd[win];
            e_ws  = ws[win];
        end
        @(negedge clk);
    endtask

    // Asserts reset at a negedge, checks outputs at once, releases at the next negedge.
    task automatic do_reset();
        m_req_valid = 2'b11;
        s_rsp_valid = 1'b1;
        s_req_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("rst_s_req_valid", s_req_valid, 1'b0);
        check("rst_m_req_ready", m_req_ready, 2'b00);
        check("rst_m_rsp_valid", m_rsp_valid, 2'b00);
        owner_q.delete();
        mem_pend    = 0;
        mv          = 1'b0;
        rr          = 1'b1;
        pend[0]     = 1'b0;
        pend[1]     = 1'b0;
        m_req_valid = 2'b00;
        s_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        m_req_valid = 2'b00;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_rdata = 32'h0;
        s_rsp_err   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            adr[i] = 32'h0; wr[i] = 1'b0; wd[i] = 32'h0; ws[i] = 4'h0;
        end
        @(negedge clk);
        do_reset();

        // Single fetch with response two cycles after the grant
        adr[0] = 32'h0001_0000; wr[0] = 1'b0;
        m_req_valid = 2'b01; s_req_ready = 1'b1;
        #1 check("t1_grant", m_req_ready, 2'b01);
        step();
        m_req_valid = 2'b00;
        #1 check("t1_s_valid", s_req_valid, 1'b1);
        check("t1_s_adr", s_req_adr, 32'h0001_0000);
        check("t1_s_write", s_req_write, 1'b0);
        step();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0000_0013; s_rsp_err = 1'b0;
        #1 check("t1_rsp_valid", m_rsp_valid, 2'b01);
        check("t1_rsp_rdata", m_rsp_rdata, 32'h0000_0013);
        step();
        s_rsp_valid = 1'b0;
        step();

        // Contention: grant order 1,0,1,0 after reset
        do_reset();
        adr[0] = 32'h0000_0100; adr[1] = 32'h0000_0200;
        s_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_req_valid = 2'b11;
            #1 check("t2_grant", m_req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) check("t2_s_adr", s_req_adr, (k % 2 == 1) ? 32'h200 : 32'h100);
            step();
        end
        m_req_valid = 2'b00;
        step();

        // Backpressure: a held write while another requester waits
        do_reset();
        adr[1] = 32'h0002_0004; wr[1] = 1'b1; wd[1] = 32'hDEAD_BEEF; ws[1] = 4'hF;
        adr[0] = 32'h0000_3000; wr[0] = 1'b0;
        m_req_valid = 2'b10; s_req_ready = 1'b0;
        step();
        m_req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1 check("t3_hold_adr", s_req_adr, 32'h0002_0004);
            check("t3_hold_wdata", s_req_wdata, 32'hDEAD_BEEF);
            check("t3_hold_wstrb", s_req_wstrb, 4'hF);
            check("t3_hold_ready", m_req_ready, 2'b00);
            step();
        end
        s_req_ready = 1'b1;
        step();
        m_req_valid = 2'b00;
        step();

        // Outstanding limit: fifth request waits one cycle past the freeing response
        do_reset();
        s_req_ready = 1'b1; m_req_valid = 2'b01;
        for (int k = 0; k < 4; k++) step();
        #1 check("t4_full", m_req_ready, 2'b00);
        step();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h55; s_rsp_err = 1'b0;
        #1 check("t4_same_cycle", m_req_ready, 2'b00);
        step();
        s_rsp_valid = 1'b0;
        #1 check("t4_next_cycle", m_req_ready, 2'b01);
        step();
        m_req_valid = 2'b00;
        step();

        // Ordering: issue 0,1,1,0 then in-order responses, error on the third
        do_reset();
        s_req_ready = 1'b1;
        m_req_valid = 2'b01; step();
        m_req_valid = 2'b10; step();
        m_req_valid = 2'b10; step();
        m_req_valid = 2'b01; step();
        m_req_valid = 2'b00; step();
        for (int k = 0; k < 4; k++) begin
            s_rsp_valid = 1'b1;
            s_rsp_rdata = 32'hA + 32'(k);
            s_rsp_err   = (k == 2);
            #1 check("t5_rsp_valid", m_rsp_valid, (k == 0 || k == 3) ? 2'b01 : 2'b10);
            check("t5_rsp_rdata", m_rsp_rdata, 32'hA + 32'(k));
            check("t5_rsp_err", m_rsp_err, (k == 2) ? 1'b1 : 1'b0);
            step();
        end
        s_rsp_valid = 1'b0;

        // Reset with two requests outstanding, then a stray response
        do_reset();
        s_req_ready = 1'b1;
        m_req_valid = 2'b01; step();
        m_req_valid = 2'b10; step();
        m_req_valid = 2'b00; s_req_ready = 1'b0;
        #1 check("t6_pre_valid", s_req_valid, 1'b1);
        do_reset();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h77;
        #1 check("t6_stray", m_rsp_valid, 2'b00);
        step();
        s_rsp_valid = 1'b0;
        step();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    adr[i]  = $urandom;
                    wr[i]   = 1'($urandom_range(0, 1));
                    wd[i]   = $urandom;
                    ws[i]   = 4'($urandom);
                end
            end
            m_req_valid = {pend[1], pend[0]};
            s_req_ready = ($urandom_range(0, 3) != 0);
            s_rsp_valid = (mem_pend > 0) && ($urandom_range(0, 1) == 1);
            s_rsp_rdata = $urandom;
            s_rsp_err   = ($urandom_range(0, 7) == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                if (last_grant[i]) pend[i] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
